// File: rtl/freq_stim_gen.sv
// Frame-locked frequency stimulus generator: a phase accumulator drives vco_out,
// and the frame counter provides a reference window that is high for 2^ACC_W cycles.
module freq_stim_gen #(
    parameter int ACC_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] code_in,
    input  logic       load,
    input  logic       selec,
    output logic       vco_out,
    output logic       ref_out,
    output logic [4:0] code_active,
    output logic       pending,
    output logic       sweep_wrap
);

    logic [ACC_W:0]   r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [4:0]       r_code;
    logic [4:0]       r_pend_code;
    logic             r_pending;
    logic             r_wrap;

    logic             w_boundary;
    logic [ACC_W-1:0] w_step;

    // The last count of the frame is all ones, so the boundary is the counter's natural wrap.
    assign w_boundary = &r_cnt;
    assign w_step     = ACC_W'(r_code);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_code      <= '0;
            r_pend_code <= '0;
            r_pending   <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_wrap <= 1'b0;
            if (w_boundary) begin
                r_acc <= '0;
                if (load) begin
                    r_code    <= code_in;
                    r_pending <= 1'b0;
                end else if (r_pending) begin
                    r_code    <= r_pend_code;
                    r_pending <= 1'b0;
                end else if (selec) begin
                    r_code <= r_code + 5'd1;
                    r_wrap <= (r_code == 5'd31);
                end
            end else begin
                r_acc <= r_acc + w_step;
                if (load) begin
                    r_pend_code <= code_in;
                    r_pending   <= 1'b1;
                end
            end
        end
    end

    assign vco_out     = r_acc[ACC_W-1];
    assign ref_out     = ~r_cnt[ACC_W];
    assign code_active = r_code;
    assign pending     = r_pending;
    assign sweep_wrap  = r_wrap;

endmodule

// File: tb/tb_freq_stim_gen.sv
// Directed bench for freq_stim_gen: per-window edge counts are checked
// against codes queued when the stimulus that selects them is applied.
module tb_freq_stim_gen;

    localparam int FRAME = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] code_in = '0;
    logic       load = 1'b0;
    logic       selec = 1'b0;
    logic       vco_out;
    logic       ref_out;
    logic [4:0] code_active;
    logic       pending;
    logic       sweep_wrap;

    int errors = 0;
    int checks = 0;
    int pos = 0;
    int exp_q[$];
    bit seen5 = 0;
    bit pend_seen = 0;

    freq_stim_gen #(.ACC_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .code_in(code_in),
        .load(load),
        .selec(selec),
        .vco_out(vco_out),
        .ref_out(ref_out),
        .code_active(code_active),
        .pending(pending),
        .sweep_wrap(sweep_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // pos mirrors the DUT frame counter for the cycle that follows the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
        if (code_active == 5'd5) seen5 = 1;
        if (pending) pend_seen = 1;
    endtask

    task automatic goto(input int p);
        while (pos != p) tick();
    endtask

    task automatic do_load(input logic [4:0] c);
        code_in = c;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Must be entered at pos 0; counts vco rising edges and sweep_wrap cycles in the high window.
    task automatic check_window(input string tag, input int exp_wraps);
        int e;
        int w;
        int rerr;
        int exp_code;
        logic prev;
        e = 0;
        rerr = ref_out ? 0 : 1;
        w = sweep_wrap ? 1 : 0;
        prev = vco_out;
        repeat (255) begin
            tick();
            if (vco_out && !prev) e++;
            if (!ref_out) rerr++;
            if (sweep_wrap) w++;
            prev = vco_out;
        end
        exp_code = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk({tag, "_edges"}, e, exp_code);
        chk({tag, "_ref_hi"}, rerr, 0);
        chk({tag, "_wrap"}, w, exp_wraps);
    endtask

    initial begin
        int rerr;
        int vhi;

        // Reset and idle frame with code 0
        tick();
        pos = 0;
        reset = 1'b0;
        chk("rst_ref", int'(ref_out), 1);
        chk("rst_vco", int'(vco_out), 0);
        chk("rst_code", int'(code_active), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_wrap", int'(sweep_wrap), 0);

        rerr = 0;
        vhi = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (ref_out !== (pos < 256)) rerr++;
            if (vco_out !== 1'b0) vhi++;
            tick();
        end
        chk("ref_pattern", rerr, 0);
        chk("vco_idle", vhi, 0);

        // Mid-frame load of 17
        goto(100);
        exp_q.push_back(17);
        exp_q.push_back(17);
        do_load(5'd17);
        chk("l17_pending", int'(pending), 1);
        chk("l17_code_hold", int'(code_active), 0);
        goto(511);
        chk("l17_pending_bnd", int'(pending), 1);
        tick();
        chk("l17_code", int'(code_active), 17);
        chk("l17_pending_clr", int'(pending), 0);
        check_window("w17a", 0);
        goto(511);
        tick();
        check_window("w17b", 0);

        // Two loads in one frame: the last wins
        goto(50);
        seen5 = 0;
        do_load(5'd5);
        goto(60);
        exp_q.push_back(9);
        do_load(5'd9);
        goto(511);
        tick();
        chk("l9_code", int'(code_active), 9);
        chk("l9_no5", int'(seen5), 0);
        check_window("w9", 0);

        // Load exactly at the boundary
        goto(510);
        tick();
        pend_seen = 0;
        exp_q.push_back(12);
        do_load(5'd12);
        chk("l12_code", int'(code_active), 12);
        check_window("w12", 0);
        chk("l12_no_pending", int'(pend_seen), 0);

        // Sweep 30 -> 31 -> 0
        goto(100);
        exp_q.push_back(30);
        do_load(5'd30);
        goto(511);
        tick();
        chk("sw_code30", int'(code_active), 30);
        check_window("w30", 0);
        goto(300);
        selec = 1'b1;
        exp_q.push_back(31);
        exp_q.push_back(0);
        tick();
        goto(511);
        chk("sw_mid_hold", int'(code_active), 30);
        tick();
        chk("sw_code31", int'(code_active), 31);
        check_window("w31", 0);
        goto(511);
        chk("sw_wrap_pre", int'(sweep_wrap), 0);
        tick();
        chk("sw_code0", int'(code_active), 0);
        chk("sw_wrap_pulse", int'(sweep_wrap), 1);
        check_window("w0", 1);
        selec = 1'b0;
        goto(511);
        tick();

        // Reset mid-frame with a pending code and a simultaneous load
        goto(200);
        do_load(5'd7);
        goto(300);
        chk("rst2_pend_before", int'(pending), 1);
        reset = 1'b1;
        code_in = 5'd21;
        load = 1'b1;
        tick();
        pos = 0;
        reset = 1'b0;
        load = 1'b0;
        chk("rst2_code", int'(code_active), 0);
        chk("rst2_pending", int'(pending), 0);
        chk("rst2_ref", int'(ref_out), 1);
        chk("rst2_vco", int'(vco_out), 0);
        chk("rst2_wrap", int'(sweep_wrap), 0);
        goto(511);
        tick();
        chk("rst2_code_lost", int'(code_active), 0);
        chk("rst2_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/freq_stim_gen.md
FREQ_STIM_GEN -- requirements
Module: freq_stim_gen

Interface
REQ-001 The block SHALL have parameter ACC_W, default 8: phase-accumulator width; the half reference period REF_HALF SHALL equal 2^ACC_W clk cycles.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port `clk` SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port `reset` SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port `code_in` SHALL be an input, 5 bits: requested frequency code, 0..31.
REQ-006 Port `load` SHALL be an input, 1 bit: a one-cycle strobe that captures `code_in`.
REQ-007 Port `selec` SHALL be an input, 1 bit, selecting the mode: 0 = fixed code, 1 = sweep.
REQ-008 Port `vco_out` SHALL be an output, 1 bit: synthesized oscillator-like square wave.
REQ-009 Port `ref_out` SHALL be an output, 1 bit: measurement reference, high for REF_HALF cycles and low for REF_HALF cycles.
REQ-010 Port `code_active` SHALL be an output, 5 bits: the code currently driving `vco_out`.
REQ-011 Port `pending` SHALL be an output, 1 bit: a loaded code is waiting for the next frame boundary.
REQ-012 Port `sweep_wrap` SHALL be an output, 1 bit: one-cycle pulse when the sweep code wraps from 31 to 0.

Function
REQ-013 Frame counter `cnt` SHALL be ACC_W+1 bits and increment by 1 each cycle; at 2*REF_HALF-1 it SHALL wrap to 0.
- That wrap cycle is the frame boundary.
REQ-014 `ref_out` SHALL be 1 exactly when `cnt` < REF_HALF, decoded from the registered `cnt` only.
REQ-015 Phase accumulator `acc` (ACC_W bits) SHALL update as follows:
- at the frame boundary: acc <= 0;
- otherwise: acc <= acc + code_active, modulo 2^ACC_W.
REQ-016 `vco_out` SHALL equal acc[ACC_W-1].
- Consequence: during each ref_out-high window, `vco_out` shows exactly `code_active` rising edges.
REQ-017 On `load`=1 in a non-boundary cycle, the block SHALL register `code_in` into the pending register and set `pending`=1.
- A load while `pending`=1 overwrites the pending code; the last load wins.
REQ-018 On `load`=1 in the boundary cycle, `code_active` SHALL take `code_in` directly and `pending` SHALL clear.
REQ-019 At a boundary with `pending`=1 and no `load`, `code_active` SHALL take the pending code and `pending` SHALL clear; this applies regardless of `selec`.
REQ-020 At a boundary with `pending`=0, no `load` and `selec`=1, `code_active` SHALL increment by 1 modulo 32.
- When it goes from 31 to 0, `sweep_wrap` SHALL pulse high in the following cycle only.
REQ-021 At a boundary with `pending`=0, no `load` and `selec`=0, `code_active` SHALL hold.
REQ-022 `code_active` SHALL change only at frame boundaries, so a measurement window never mixes two codes.
REQ-023 Changes to `selec` SHALL take effect at the next boundary only; a mid-frame toggle causes no glitch on `vco_out`.
REQ-024 With `code_active`=0, `vco_out` SHALL stay at 0.

Reset
REQ-025 While `reset`=1 at a clock edge, the block SHALL set cnt=0, acc=0, code_active=0, pending register=0, pending=0, sweep_wrap=0.
- Resulting outputs: vco_out=0, ref_out=1.
REQ-026 `reset` SHALL override `load` and any frame in progress; the first cycle after release is cnt=0, the start of a new frame.
REQ-027 A `load` sampled in the same cycle as `reset`=1 SHALL be discarded.

Verification
REQ-028 Reset release with ACC_W=8 -> ref_out=1 for 256 cycles then 0 for 256 cycles, repeating; vco_out=0; code_active=0.
REQ-029 load code_in=17 mid-frame (cnt=100), selec=0 -> pending=1 until the boundary; code_active=17 from the next frame; exactly 17 vco_out rising edges in each following ref_out-high window.
REQ-030 load 5 then load 9 in the same frame -> code_active=9 at the boundary; one 5 is never observed.
REQ-031 load 12 exactly in the boundary cycle -> code_active=12 in the immediately following frame; pending never asserts.
REQ-032 selec=1 starting from code_active=30 -> 31 next frame, then 0 with a single-cycle sweep_wrap pulse; edge counts per window track 30, 31, 0.
REQ-033 reset asserted at cnt=300 with pending=1 -> all outputs at reset values next cycle; the pending code is lost.
